ex_mem_pipe_stage: RTL
======================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline boundary register with valid/ready handshake and a
//  2-entry skid buffer, so MEM-side back-pressure never combinationally reaches EX.
//  Carries ALU result, store data, branch target, zero flag, destination register
//  and reg-write enable.
//  Adds stall, flush (branch squash) and bubble tracking for the hazard unit.
//  Sits between the execute stage and data-memory stage of the pipeline.
// PARAMETERS
//  DATA_W  32  width of result and store-data (registro_2) fields
//  ADDR_W  11  width of branch/jump destination address
//  REG_W   5   width of destination register index
// PORTS
//  clock              in   1       rising-edge clock
//  reset_n            in   1       asynchronous active-low reset
//  flush              in   1       squash all held entries (sync, takes effect at edge)
//  in_valid           in   1       EX presents a valid instruction
//  in_ready           out  1       stage can accept (registered: !skid_full)
//  result_in          in   DATA_W  ALU result
//  registro_2_in      in   DATA_W  store data (rt value)
//  jump_dest_addr_in  in   ADDR_W  branch target
//  zero_signal_in     in   1       ALU zero flag
//  reg_dest_in        in   REG_W   destination register index
//  reg_write_in       in   1       destination write enable
//  out_valid          out  1       MEM-side entry valid
//  out_ready          in   1       MEM consumes entry this cycle
//  result_out / registro_2_out / jump_dest_addr_out / zero_signal_out /
//  reg_dest_out / reg_write_out   out  matching widths   head-entry fields
//  occupancy          out  2       entries held (0..2)
// BEHAVIOUR
//  - Storage: MAIN register (drives outputs) + SKID register; valids main_v, skid_v.
//  - accept = in_valid & in_ready; drain = out_valid & out_ready.
//  - States (occupancy): EMPTY(0), ONE(1), FULL(2).
//    EMPTY: accept -> ONE, data to MAIN.
//    ONE: accept&drain -> ONE, MAIN<=in; accept&!drain -> FULL, SKID<=in;
//         !accept&drain -> EMPTY; else hold.
//    FULL: drain -> ONE, MAIN<=SKID; no accept possible (in_ready=0).
//  - Latency 1 cycle EMPTY->out_valid; throughput 1/cycle with out_ready held high.
//  - FIFO order is strictly preserved; no entry duplicated or dropped.
//  - in_ready = !skid_v, a flop output only; it depends on no same-cycle input.
//  - Outputs stable while out_valid & !out_ready (all fields hold bit-exact).
//  - out_valid=0 (bubble): data outputs hold last value; reg_write_out forced 0.
//  - flush: next edge main_v=skid_v=0, occupancy=0, in_ready=1. Flush beats a
//    same-cycle accept (input discarded). A same-cycle drain still counts as consumed.
//  - Reset (async, reset_n=0): main_v=skid_v=0, all data outputs 0, occupancy 0,
//    in_ready=1. Applies immediately, even mid-transfer; release is sync to clock.
//  - No arithmetic; all fields pass width-exact, no extension or truncation.
// TESTING
//  1. Reset mid-stream with FULL -> out_valid=0, outputs 0, in_ready=1 before next edge.
//  2. out_ready=1, stream results 1..8 -> outputs 1..8 on consecutive cycles,
//     1-cycle latency.
//  3. out_ready=0, push A=0x11, B=0x22 -> occupancy 2, in_ready=0, out A held;
//     release -> A then B.
//  4. FULL plus flush with in_valid=1, C=0x33 -> next cycle occupancy 0, C never emitted.
//  5. Alternate out_ready 1/0 with random in_valid, 1000 cycles -> scoreboard order and
//     count exact.
//  6. Bubble with reg_write_in=1 but in_valid=0 -> reg_write_out=0.

Source files
------------

// File: rtl/ex_mem_pipe_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage_if
// Purpose : bundles the EX->MEM boundary handshake and payload so the stage
//           and its neighbours connect through a single port.
// Signals : flush                 squash request from the hazard unit
//           in_valid / in_ready   EX-side handshake
//           result_in, registro_2_in, jump_dest_addr_in, zero_signal_in,
//           reg_dest_in, reg_write_in                 EX-side payload
//           out_valid / out_ready MEM-side handshake
//           result_out, registro_2_out, jump_dest_addr_out, zero_signal_out,
//           reg_dest_out, reg_write_out               MEM-side payload
//           occupancy             entries currently held (0..2)
// Modports: slave  - the pipeline stage itself
//           master - the environment driving EX side and consuming MEM side
// ---------------------------------------------------------------------------
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int REG_W  = 5
);
  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result_in;
  logic [DATA_W-1:0] registro_2_in;
  logic [ADDR_W-1:0] jump_dest_addr_in;
  logic              zero_signal_in;
  logic [REG_W-1:0]  reg_dest_in;
  logic              reg_write_in;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] registro_2_out;
  logic [ADDR_W-1:0] jump_dest_addr_out;
  logic              zero_signal_out;
  logic [REG_W-1:0]  reg_dest_out;
  logic              reg_write_out;

  logic [1:0]        occupancy;

  modport slave (
    input  flush,
    input  in_valid, result_in, registro_2_in, jump_dest_addr_in,
           zero_signal_in, reg_dest_in, reg_write_in,
    output in_ready,
    output out_valid, result_out, registro_2_out, jump_dest_addr_out,
           zero_signal_out, reg_dest_out, reg_write_out,
    input  out_ready,
    output occupancy
  );

  modport master (
    output flush,
    output in_valid, result_in, registro_2_in, jump_dest_addr_in,
           zero_signal_in, reg_dest_in, reg_write_in,
    input  in_ready,
    input  out_valid, result_out, registro_2_out, jump_dest_addr_out,
           zero_signal_out, reg_dest_out, reg_write_out,
    output out_ready,
    input  occupancy
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_stage
// Purpose : EX->MEM pipeline boundary register with a valid/ready handshake
//           and a 2-entry skid buffer (MAIN + SKID). in_ready is a pure flop
//           output, so MEM back-pressure never combinationally reaches EX.
//           Supports flush (branch squash) and exposes occupancy for the
//           hazard unit.
// Ports   : clock    rising-edge clock
//           reset_n  asynchronous active-low reset
//           bus      ex_mem_pipe_stage_if.slave (handshakes, payload,
//                    flush, occupancy)
// ---------------------------------------------------------------------------
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int REG_W  = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  ex_mem_pipe_stage_if.slave      bus
);

  // Payload packed as {result, registro_2, jump_dest, zero, reg_dest, reg_write}
  localparam int ENT_W = 2*DATA_W + ADDR_W + REG_W + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occupancy_q;
  logic [ENT_W-1:0]  main_q;
  logic [ENT_W-1:0]  skid_q;

  logic [ENT_W-1:0]  in_ent;
  logic              accept;
  logic              drain;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign in_ent = {bus.result_in, bus.registro_2_in, bus.jump_dest_addr_in,
                   bus.zero_signal_in, bus.reg_dest_in, bus.reg_write_in};

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      // Flush wins over a same-cycle accept; a same-cycle drain has already
      // been seen by MEM, so dropping it here loses nothing.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (drain) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      // Handshake flags are registered from the next state so they are
      // glitch-free flop outputs.
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      occupancy_q <= state_d;
      if (load_main_in) begin
        main_q <= in_ent;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_ent;
      end
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.occupancy          = occupancy_q;
  assign bus.result_out         = main_q[ENT_W-1 -: DATA_W];
  assign bus.registro_2_out     = main_q[ENT_W-DATA_W-1 -: DATA_W];
  assign bus.jump_dest_addr_out = main_q[REG_W+2 +: ADDR_W];
  assign bus.zero_signal_out    = main_q[REG_W+1];
  assign bus.reg_dest_out       = main_q[1 +: REG_W];
  // A bubble must never write the register file, even though the payload
  // flops keep their last value.
  assign bus.reg_write_out      = main_q[0] & out_valid_q;

endmodule
